mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Round-robin on contention, one outstanding transaction, WAIT timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_done,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       win_d;
    logic       last_d;
    logic       abort;
    logic [7:0] cnt;
    logic       grant_d;
    logic       tmo;
    logic       any_req;

    // Data wins when alone, or on contention when fetch went last.
    assign grant_d = d_req && (!f_req || !last_d);
    assign any_req = f_req || d_req;
    assign tmo     = (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (any_req) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (mem_done || tmo) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        mem_req     = (state == S_ISSUE);
        f_ack       = (state == S_RESP) && !win_d;
        d_ack       = (state == S_RESP) && win_d;
        timeout_err = (state == S_RESP) && abort;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_d     <= 1'b0;
            last_d    <= 1'b1;
            abort     <= 1'b0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        win_d     <= grant_d;
                        mem_addr  <= grant_d ? d_addr : f_addr;
                        mem_we    <= grant_d && d_we;
                        mem_wdata <= grant_d ? d_wdata : '0;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    abort <= 1'b0;
                end
                S_WAIT: begin
                    if (mem_done || tmo) begin
                        // An aborted read returns zero rather than stale data.
                        abort <= !mem_done;
                        if (!win_d) begin
                            f_rdata <= mem_done ? mem_rdata[31:0] : '0;
                        end else if (!mem_we) begin
                            d_rdata <= mem_done ? mem_rdata : '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    last_d <= win_d;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// contention and reset-in-WAIT sequences.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_done;
    logic        busy;
    logic        timeout_err;

    int n_tests;
    int n_fail;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk),
        .reset(reset),
        .f_req(f_req),
        .f_addr(f_addr),
        .f_ack(f_ack),
        .f_rdata(f_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ack(d_ack),
        .d_rdata(d_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_done(mem_done),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [63:0] d_wdata;
        logic [63:0] rdata;
        int          done_at;
        logic        stray;
        logic        exp_d;
        int          exp_ack;
        logic        exp_to;
        logic [31:0] exp_f;
        logic [63:0] exp_dr;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        f_req    = 1'b0;
        d_req    = 1'b0;
        mem_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_ctrl"},
              128'({mem_req, mem_we, f_ack, d_ack, busy, timeout_err}),
              128'(6'b0));
        check({p, "_maddr"}, 128'(mem_addr), 128'(32'h0));
        check({p, "_mwdata"}, 128'(mem_wdata), 128'(64'h0));
        check({p, "_frdata"}, 128'(f_rdata), 128'(32'h0));
        check({p, "_drdata"}, 128'(d_rdata), 128'(64'h0));
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [31:0] ea;
        logic        ewe;
        logic [63:0] ewd;
        logic        stable_ok;
        int          ack_n;
        v   = tbl[i];
        ea  = v.exp_d ? v.d_addr : v.f_addr;
        ewe = v.exp_d & v.d_we;
        ewd = v.exp_d ? v.d_wdata : 64'h0;
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", i), 128'(busy), 128'(1'b0));
        f_req     = v.f_req;
        f_addr    = v.f_addr;
        d_req     = v.d_req;
        d_we      = v.d_we;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        mem_rdata = v.rdata;
        mem_done  = v.stray;
        ack_n     = -1;
        stable_ok = 1'b1;
        for (int n = 1; n <= 12 && ack_n < 0; n++) begin
            @(negedge clk);
            mem_done = (v.stray && n == 1) || (n == 2 + v.done_at);
            if (n == 1) begin
                check($sformatf("v%0d_issue", i),
                      128'({mem_req, mem_we, mem_addr, mem_wdata}),
                      128'({1'b1, ewe, ea, ewd}));
            end else if (mem_req || mem_addr !== ea || mem_we !== ewe ||
                         mem_wdata !== ewd) begin
                stable_ok = 1'b0;
            end
            if (f_ack || d_ack) begin
                ack_n = n;
                check($sformatf("v%0d_ack_kind", i),
                      128'({f_ack, d_ack, timeout_err}),
                      128'({~v.exp_d, v.exp_d, v.exp_to}));
                check($sformatf("v%0d_f_rdata", i), 128'(f_rdata),
                      128'(v.exp_f));
                check($sformatf("v%0d_d_rdata", i), 128'(d_rdata),
                      128'(v.exp_dr));
                f_req    = 1'b0;
                d_req    = 1'b0;
                mem_done = 1'b0;
            end else if (timeout_err) begin
                stable_ok = 1'b0;
            end
        end
        check($sformatf("v%0d_ack_cycle", i), 128'(ack_n), 128'(v.exp_ack));
        check($sformatf("v%0d_stable", i), 128'(stable_ok), 128'(1'b1));
        f_req    = 1'b0;
        d_req    = 1'b0;
        mem_done = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_after", i),
              128'({busy, f_ack, d_ack, timeout_err}), 128'(4'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] order;
        int         nacks;
        int         prev;
        logic       overlap;
        logic       spacing_ok;
        logic       quiet_ok;

        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        f_req     = 1'b0;
        f_addr    = 32'h0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 64'h0;
        mem_rdata = 64'h0;
        mem_done  = 1'b0;

        tbl[0] = '{1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 64'h0,
                   64'h11223344_AABBCCDD, 0, 1'b0,
                   1'b0, 3, 1'b0, 32'hAABBCCDD, 64'h0};
        tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h7FFF8, 64'hDEADBEEF_00000001,
                   64'h55555555_55555555, 0, 1'b0,
                   1'b1, 3, 1'b0, 32'hAABBCCDD, 64'h0};
        tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 64'h0,
                   64'h01234567_89ABCDEF, 2, 1'b0,
                   1'b1, 5, 1'b0, 32'hAABBCCDD, 64'h01234567_89ABCDEF};
        tbl[3] = '{1'b1, 32'h3000, 1'b1, 1'b1, 32'h200, 64'h77,
                   64'hCAFEF00D_12345678, 1, 1'b0,
                   1'b0, 4, 1'b0, 32'h12345678, 64'h01234567_89ABCDEF};
        tbl[4] = '{1'b1, 32'h3004, 1'b1, 1'b0, 32'h40, 64'h0,
                   64'h0F1E2D3C_4B5A6978, 3, 1'b0,
                   1'b1, 6, 1'b0, 32'h12345678, 64'h0F1E2D3C_4B5A6978};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 64'hFFFF0000_FFFF0000,
                   64'h1111, 99, 1'b0,
                   1'b1, 6, 1'b1, 32'h12345678, 64'h0F1E2D3C_4B5A6978};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h88, 64'h0,
                   64'h22223333, 99, 1'b0,
                   1'b1, 6, 1'b1, 32'h12345678, 64'h0};
        tbl[7] = '{1'b1, 32'h4000, 1'b0, 1'b0, 32'h0, 64'h0,
                   64'h44445555, 99, 1'b1,
                   1'b0, 6, 1'b1, 32'h0, 64'h0};
        tbl[8] = '{1'b1, 32'h4004, 1'b0, 1'b0, 32'h0, 64'h0,
                   64'h99999999_87654321, 1, 1'b1,
                   1'b0, 4, 1'b0, 32'h87654321, 64'h0};

        do_reset();
        check_reset_vals("rst0");

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
        end

        // Both requesters held, memory always ready: F,D,F,D every 4 cycles.
        do_reset();
        f_req      = 1'b1;
        d_req      = 1'b1;
        f_addr     = 32'h5000;
        d_addr     = 32'h6000;
        d_we       = 1'b0;
        mem_rdata  = 64'hA5A5A5A5_5A5A5A5A;
        mem_done   = 1'b1;
        order      = 4'b0;
        nacks      = 0;
        prev       = -1;
        overlap    = 1'b0;
        spacing_ok = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (f_ack && d_ack) overlap = 1'b1;
            if (f_ack || d_ack) begin
                if (prev >= 0 && n - prev != 4) spacing_ok = 1'b0;
                prev  = n;
                order = {order[2:0], d_ack};
                nacks++;
            end
        end
        f_req    = 1'b0;
        d_req    = 1'b0;
        mem_done = 1'b0;
        check("rr_count", 128'(nacks), 128'(4));
        check("rr_order", 128'(order), 128'(4'b0101));
        check("rr_overlap", 128'(overlap), 128'(1'b0));
        check("rr_spacing", 128'(spacing_ok), 128'(1'b1));

        // Reset while in WAIT, then a late mem_done.
        do_reset();
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h8000;
        mem_rdata = 64'hFEEDFACE_CAFEBABE;
        @(negedge clk);
        check("rw_issue", 128'({mem_req, mem_addr}),
              128'({1'b1, 32'h8000}));
        @(negedge clk);
        check("rw_in_wait", 128'({busy, mem_req}), 128'(2'b10));
        reset = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        mem_done = 1'b1;
        check_reset_vals("rw");
        quiet_ok = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            mem_done = 1'b0;
            if (f_ack || d_ack || timeout_err || busy || mem_req) begin
                quiet_ok = 1'b0;
            end
        end
        check("rw_quiet", 128'(quiet_ok), 128'(1'b1));
        check("rw_drdata", 128'(d_rdata), 128'(64'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
